// File: rtl/ex_stage.sv
// Execute stage of the RV32 pipeline: forward muxes, single-cycle ALU, optional
// iterative divider (enabled by defining EX_DIV_EN) and the EX/MEM register.
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_EX,
    input  logic            flush_EX,
    input  logic [3:0]      alu_op_EX,
    input  logic            ALUSrc_EX,
    input  logic [4:0]      rd_EX,
    input  logic            RegWrite_EX,
    input  logic            MemRead_EX,
    input  logic            MemWrite_EX,
    input  logic [XLEN-1:0] rs1_data_EX,
    input  logic [XLEN-1:0] rs2_data_EX,
    input  logic [XLEN-1:0] imm_EX,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] wb_data_WB,
    output logic            busy_EX,
    output logic [XLEN-1:0] alu_result_MEM,
    output logic [XLEN-1:0] store_data_MEM,
    output logic [4:0]      rd_MEM,
    output logic            RegWrite_MEM,
    output logic            MemRead_MEM,
    output logic            MemWrite_MEM
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_result;
    logic [4:0]      shamt;
    logic            busy;

    always_comb begin
        case (forwardA)
            2'b01:   op_a = wb_data_WB;
            2'b10:   op_a = alu_result_MEM;
            default: op_a = rs1_data_EX;
        endcase
        case (forwardB)
            2'b01:   fwd_b = wb_data_WB;
            2'b10:   fwd_b = alu_result_MEM;
            default: fwd_b = rs2_data_EX;
        endcase
        op_b  = ALUSrc_EX ? imm_EX : fwd_b;
        shamt = op_b[4:0];
    end

    always_comb begin
        alu_res = '0;
        case (alu_op_EX)
            4'h0:    alu_res = op_a + op_b;
            4'h1:    alu_res = op_a - op_b;
            4'h2:    alu_res = op_a & op_b;
            4'h3:    alu_res = op_a | op_b;
            4'h4:    alu_res = op_a ^ op_b;
            4'h5:    alu_res = op_a << shamt;
            4'h6:    alu_res = op_a >> shamt;
            4'h7:    alu_res = $signed(op_a) >>> shamt;
            4'h8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'h9:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'hE:    alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} div_state_t;
    localparam int CW = $clog2(DIV_CYCLES + 1);

    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvsr_q, dvnd_q;
    logic            negq_q, negr_q, rem_op_q, div0_q;
    logic            is_div, div_start, div_done;
    logic            ent_neg_a, ent_neg_b;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] quo_fix, rem_fix, div_res;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = div_start ? S_RUN : S_IDLE;
            S_RUN: begin
                if (flush_EX)                          state_d = S_IDLE;
                else if (cnt_q == CW'(DIV_CYCLES - 1)) state_d = S_DONE;
                else                                   state_d = S_RUN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        is_div    = (alu_op_EX >= 4'hA) && (alu_op_EX <= 4'hD);
        div_start = (state_q == S_IDLE) && valid_EX && is_div && !flush_EX;
        div_done  = (state_q == S_DONE);
        busy      = rst_n && (div_start || (state_q == S_RUN));
    end

    // Signed ops (A, C) have bit 0 clear; magnitudes are divided, signs fixed up at DONE.
    always_comb begin
        ent_neg_a = !alu_op_EX[0] && op_a[XLEN-1];
        ent_neg_b = !alu_op_EX[0] && op_b[XLEN-1];
        rem_sh    = {rem_q, quo_q[XLEN-1]};
        diff      = rem_sh - {1'b0, dvsr_q};
        quo_fix   = negq_q ? -quo_q : quo_q;
        rem_fix   = negr_q ? -rem_q : rem_q;
        if (div0_q) div_res = rem_op_q ? dvnd_q : '1;
        else        div_res = rem_op_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            dvnd_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            rem_op_q <= 1'b0;
            div0_q   <= 1'b0;
        end else if (div_start) begin
            cnt_q    <= '0;
            quo_q    <= ent_neg_a ? -op_a : op_a;
            rem_q    <= '0;
            dvsr_q   <= ent_neg_b ? -op_b : op_b;
            dvnd_q   <= op_a;
            negq_q   <= ent_neg_a ^ ent_neg_b;
            negr_q   <= ent_neg_a;
            rem_op_q <= alu_op_EX[2];
            div0_q   <= (op_b == '0);
        end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q + CW'(1);
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign ex_result = div_done ? div_res : alu_res;
`else
    assign busy      = 1'b0;
    assign ex_result = alu_res;
`endif

    assign busy_EX = busy;

    // Stalled or flushed cycles insert a bubble: control cleared, data held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_result_MEM <= '0;
            store_data_MEM <= '0;
            rd_MEM         <= 5'd0;
            RegWrite_MEM   <= 1'b0;
            MemRead_MEM    <= 1'b0;
            MemWrite_MEM   <= 1'b0;
        end else if (flush_EX || busy) begin
            RegWrite_MEM   <= 1'b0;
            MemRead_MEM    <= 1'b0;
            MemWrite_MEM   <= 1'b0;
        end else begin
            alu_result_MEM <= ex_result;
            store_data_MEM <= fwd_b;
            rd_MEM         <= rd_EX;
            RegWrite_MEM   <= RegWrite_EX && valid_EX;
            MemRead_MEM    <= MemRead_EX && valid_EX;
            MemWrite_MEM   <= MemWrite_EX && valid_EX;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divider scenarios run when EX_DIV_EN is defined.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_EX, flush_EX, ALUSrc_EX;
    logic [3:0]  alu_op_EX;
    logic [4:0]  rd_EX;
    logic        RegWrite_EX, MemRead_EX, MemWrite_EX;
    logic [31:0] rs1_data_EX, rs2_data_EX, imm_EX, wb_data_WB;
    logic [1:0]  forwardA, forwardB;
    logic        busy_EX;
    logic [31:0] alu_result_MEM, store_data_MEM;
    logic [4:0]  rd_MEM;
    logic        RegWrite_MEM, MemRead_MEM, MemWrite_MEM;

    int tests_run = 0;
    int fails     = 0;

    ex_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_EX(valid_EX), .flush_EX(flush_EX),
        .alu_op_EX(alu_op_EX), .ALUSrc_EX(ALUSrc_EX), .rd_EX(rd_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .imm_EX(imm_EX),
        .forwardA(forwardA), .forwardB(forwardB), .wb_data_WB(wb_data_WB),
        .busy_EX(busy_EX), .alu_result_MEM(alu_result_MEM), .store_data_MEM(store_data_MEM),
        .rd_MEM(rd_MEM), .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic src, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw, input logic v);
        alu_op_EX = op; rs1_data_EX = a; rs2_data_EX = b; imm_EX = imm; ALUSrc_EX = src;
        rd_EX = rd; RegWrite_EX = rw; MemRead_EX = mr; MemWrite_EX = mw; valid_EX = v;
        forwardA = 2'b00; forwardB = 2'b00; flush_EX = 1'b0;
    endtask

    task automatic test_reset();
        present(4'hA, 32'd8, 32'd2, 32'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        wb_data_WB = 32'd0;
        rst_n = 1'b0;
        step(); step();
        tests_run++;
        if ({alu_result_MEM, store_data_MEM, rd_MEM, RegWrite_MEM, MemRead_MEM, MemWrite_MEM} !== 72'd0) begin
            fails++; $display("FAIL reset_outputs: got res=%h sd=%h rd=%0d ctl=%b%b%b, want all 0",
                alu_result_MEM, store_data_MEM, rd_MEM, RegWrite_MEM, MemRead_MEM, MemWrite_MEM);
        end
        tests_run++;
        if (busy_EX !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_EX); end
        valid_EX = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        present(4'h0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        tests_run++;
        if (alu_result_MEM !== 32'd12 || rd_MEM !== 5'd3 || RegWrite_MEM !== 1'b1 || store_data_MEM !== 32'd7) begin
            fails++; $display("FAIL add: got res=%0d rd=%0d rw=%b sd=%0d, want 12 3 1 7",
                alu_result_MEM, rd_MEM, RegWrite_MEM, store_data_MEM);
        end
    endtask

    task automatic test_forward();
        present(4'h1, 32'hDEAD_BEEF, 32'd0, 32'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        forwardA = 2'b10;
        step();
        tests_run++;
        if (alu_result_MEM !== 32'd10 || MemWrite_MEM !== 1'b1) begin
            fails++; $display("FAIL fwd_mem_sub: got res=%h mw=%b, want 0000000a 1", alu_result_MEM, MemWrite_MEM);
        end
        present(4'h7, 32'h1111_1111, 32'h2222_2222, 32'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        forwardA = 2'b01; forwardB = 2'b01; wb_data_WB = 32'h8000_0000;
        step();
        tests_run++;
        if (alu_result_MEM !== 32'hF800_0000) begin
            fails++; $display("FAIL fwd_wb_sra: got %h want f8000000", alu_result_MEM);
        end
        tests_run++;
        if (store_data_MEM !== 32'h8000_0000) begin
            fails++; $display("FAIL fwd_wb_store: got %h want 80000000", store_data_MEM);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [12];
        logic [31:0] exp [12];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE, 4'hF};
        exp = '{32'h8000_01F4, 32'h7FFF_FFEC, 32'h0000_0000, 32'h8000_01F4, 32'h8000_01F4,
                32'h0000_0F00, 32'h0800_000F, 32'hF800_000F, 32'h0000_0001, 32'h0000_0000,
                32'h0000_0104, 32'h0000_0000};
        for (int i = 0; i < 12; i++) begin
            present(ops[i], 32'h8000_00F0, 32'h0000_0104, 32'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
            step();
            tests_run++;
            if (alu_result_MEM !== exp[i] || MemRead_MEM !== 1'b1) begin
                fails++; $display("FAIL alu_op_%h: got res=%h mr=%b, want %h 1", ops[i], alu_result_MEM, MemRead_MEM, exp[i]);
            end
        end
        present(4'h0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        tests_run++;
        if ({RegWrite_MEM, MemRead_MEM, MemWrite_MEM} !== 3'b000 || alu_result_MEM !== 32'd2) begin
            fails++; $display("FAIL invalid_gating: got ctl=%b%b%b res=%h, want 000 2",
                RegWrite_MEM, MemRead_MEM, MemWrite_MEM, alu_result_MEM);
        end
        present(4'h0, 32'd40, 32'd2, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        flush_EX = 1'b1;
        step();
        tests_run++;
        if (RegWrite_MEM !== 1'b0 || alu_result_MEM !== 32'd2 || rd_MEM !== 5'd2) begin
            fails++; $display("FAIL flush_bubble: got rw=%b res=%h rd=%0d, want 0 2 2", RegWrite_MEM, alu_result_MEM, rd_MEM);
        end
        flush_EX = 1'b0; valid_EX = 1'b0;
    endtask

`ifdef EX_DIV_EN
    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int busy_cnt;
        int bubble_err;
        busy_cnt = 0; bubble_err = 0;
        present(op, a, b, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && busy_EX === 1'b1; i++) begin
            busy_cnt++;
            step();
            if (RegWrite_MEM !== 1'b0) bubble_err++;
        end
        tests_run++;
        if (busy_cnt != 33 || bubble_err != 0) begin
            fails++; $display("FAIL div_busy_%h: got busy=%0d bubble_errs=%0d, want 33 0", op, busy_cnt, bubble_err);
        end
        step();
        tests_run++;
        if (alu_result_MEM !== exp || RegWrite_MEM !== 1'b1 || rd_MEM !== 5'd7) begin
            fails++; $display("FAIL div_result_%h: got res=%h rw=%b rd=%0d, want %h 1 7", op, alu_result_MEM, RegWrite_MEM, rd_MEM, exp);
        end
    endtask

    task automatic test_divide();
        run_div(4'hA, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div(4'hC, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div(4'hB, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_div(4'hC, 32'd9, 32'd0, 32'd9);
        run_div(4'hA, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div(4'hD, 32'd100, 32'd7, 32'd2);
        valid_EX = 1'b0;
        step();
    endtask

    task automatic test_div_flush();
        present(4'hA, 32'd100, 32'd3, 32'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step();
        flush_EX = 1'b1; valid_EX = 1'b0;
        step();
        flush_EX = 1'b0;
        tests_run++;
        if (busy_EX !== 1'b0 || RegWrite_MEM !== 1'b0) begin
            fails++; $display("FAIL div_flush: got busy=%b rw=%b, want 0 0", busy_EX, RegWrite_MEM);
        end
        step();
        tests_run++;
        if (RegWrite_MEM !== 1'b0) begin fails++; $display("FAIL div_flush_nowrite: got rw=%b want 0", RegWrite_MEM); end
        present(4'h0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        tests_run++;
        if (alu_result_MEM !== 32'd3 || RegWrite_MEM !== 1'b1 || rd_MEM !== 5'd5) begin
            fails++; $display("FAIL add_after_flush: got res=%h rw=%b rd=%0d, want 3 1 5", alu_result_MEM, RegWrite_MEM, rd_MEM);
        end
    endtask

    task automatic test_div_reset();
        present(4'hA, 32'd100, 32'd3, 32'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        tests_run++;
        if ({alu_result_MEM, store_data_MEM, rd_MEM, RegWrite_MEM, MemRead_MEM, MemWrite_MEM} !== 72'd0 || busy_EX !== 1'b0) begin
            fails++; $display("FAIL div_reset: got res=%h rd=%0d rw=%b busy=%b, want 0 0 0 0", alu_result_MEM, rd_MEM, RegWrite_MEM, busy_EX);
        end
        rst_n = 1'b1; valid_EX = 1'b0;
        #1;
        tests_run++;
        if (busy_EX !== 1'b0) begin fails++; $display("FAIL div_reset_idle: got busy=%b want 0", busy_EX); end
        step();
    endtask
`else
    task automatic test_div_disabled();
        present(4'hA, 32'd8, 32'd2, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        tests_run++;
        if (busy_EX !== 1'b0) begin fails++; $display("FAIL nodiv_busy: got %b want 0", busy_EX); end
        step();
        tests_run++;
        if (alu_result_MEM !== 32'd0 || RegWrite_MEM !== 1'b1 || rd_MEM !== 5'd6) begin
            fails++; $display("FAIL nodiv_result: got res=%h rw=%b rd=%0d, want 0 1 6", alu_result_MEM, RegWrite_MEM, rd_MEM);
        end
        present(4'hD, 32'd8, 32'd3, 32'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        tests_run++;
        if (alu_result_MEM !== 32'd0 || busy_EX !== 1'b0 || rd_MEM !== 5'd2) begin
            fails++; $display("FAIL nodiv_remu: got res=%h busy=%b rd=%0d, want 0 0 2", alu_result_MEM, busy_EX, rd_MEM);
        end
        valid_EX = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_alu_ops();
`ifdef EX_DIV_EN
        test_divide();
        test_div_flush();
        test_div_reset();
`else
        test_div_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
